// File: rtl/ce_scheduler_pkg.sv
// ce_sched_pkg -- shared constants and types for the clock-enable scheduler.
//
// Holds the default divider values for the console clock domains (the same
// values serve both NTSC and PAL master clocks), the channel index enum, and a
// helper that sizes the channel-select field.
//
// Channel numbering follows the packing of the default DIV_INIT vector
// {ch3, ch2, ch1, ch0} = {68K, Z80, FM, PSG}.
package ce_sched_pkg;

  // Default dividers. The enable period is divider + 1 master-clock cycles.
  localparam logic [7:0] DIV_M68K = 8'd6;
  localparam logic [7:0] DIV_Z80  = 8'd14;
  localparam logic [7:0] DIV_FM   = 8'd5;
  localparam logic [7:0] DIV_PSG  = 8'd14;

  // Channel index. Each value is the slice position in DIV_INIT.
  typedef enum logic [1:0] {
    CH_M68K = 2'd3,
    CH_Z80  = 2'd2,
    CH_FM   = 2'd1,
    CH_PSG  = 2'd0
  } ce_ch_e;

  // Default reset dividers, packed ch3..ch0.
  localparam logic [31:0] DIV_INIT_DEF = {DIV_M68K, DIV_Z80, DIV_FM, DIV_PSG};

  // Width of a channel-select field. It is never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ce_scheduler_channel.sv
// ce_channel -- one clock-enable channel of ce_scheduler.
//
// A free-running up-counter wraps at div_active and produces a registered,
// one-cycle cen pulse on the cycle after the wrap. A new divider arrives
// through wr_en/wr_div and parks in a pending register. The pending value is
// applied on the next wrap, or at once on resync, so no period is ever cut
// short or doubled.
//
// Ports:
//   clk, reset   master clock and asynchronous active-high reset
//   pause        level input. Holds the counter and suppresses cen.
//   resync       single-cycle input. Clears the counter and applies any pending divider.
//   wr_en        accepted config write for this channel. Only asserted while pending=0.
//   wr_div       divider value carried by the write
//   cen          registered clock-enable pulse
//   pending      an accepted divider is waiting to be applied
module ce_channel #(
  parameter int               DIV_W    = 8,
  parameter logic [DIV_W-1:0] DIV_INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pause,
  input  logic             resync,
  input  logic             wr_en,
  input  logic [DIV_W-1:0] wr_div,
  output logic             cen,
  output logic             pending
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] div_active;
  logic [DIV_W-1:0] div_pend;
  logic             wrap;

  // A wrap is a real period boundary only while the channel is running.
  assign wrap = (count == div_active) && !pause;

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples its inputs from before the edge. No ordering hazard can arise
  // between the counter, the divider and the flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= '0;
      div_active <= DIV_INIT;
      pending    <= 1'b0;
      cen        <= 1'b0;
    end else begin
      if (resync) begin
        // resync wins over pause. The phase restarts from zero with the newest divider.
        count <= '0;
        cen   <= 1'b0;
        if (pending) div_active <= div_pend;
      end else if (pause) begin
        cen <= 1'b0;
      end else if (wrap) begin
        count <= '0;
        cen   <= 1'b1;
        if (pending) div_active <= div_pend;
      end else begin
        count <= count + 1'b1;
        cen   <= 1'b0;
      end

      // wr_en only occurs while pending=0. A write that lands on the same
      // edge as a wrap or resync therefore stays pending for the next boundary.
      if (wr_en) begin
        pending <= 1'b1;
      end else if (resync || wrap) begin
        pending <= 1'b0;
      end
    end
  end

  // NOTE: div_pend is a plain data register. It is only ever read while
  // pending=1, and pending is reset, so div_pend itself needs no reset.
  always_ff @(posedge clk) begin
    if (wr_en) div_pend <= wr_div;
  end

endmodule

// File: rtl/ce_scheduler.sv
// ce_scheduler -- multi-channel clock-enable generator for the console core.
//
// Generates NUM_CH single-cycle clock-enable pulses from the master clock.
// Each channel has its own divider, and that divider can be reprogrammed at
// run time through a valid/ready port. This block decodes the target channel,
// muxes cfg_ready and fans pause and resync out to every channel.
//
// Ports:
//   clk, reset    master clock and asynchronous active-high reset
//   pause         level input. Holds all counters and suppresses all pulses.
//   resync        single-cycle input. Realigns all channel phases.
//   cfg_valid     config request valid
//   cfg_ready     config request accepted this cycle when cfg_valid=1
//   cfg_ch        target channel
//   cfg_div       new divider. The period is cfg_div+1 cycles.
//   cen           per-channel clock-enable pulses
//   cfg_pending   per-channel flag for an accepted divider that is not yet applied
module ce_scheduler
  import ce_sched_pkg::*;
#(
  parameter int                      NUM_CH   = 4,
  parameter int                      DIV_W    = 8,
  parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT = (NUM_CH*DIV_W)'(DIV_INIT_DEF),
  localparam int                     CH_W     = ch_idx_w(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pause,
  input  logic              resync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] cen,
  output logic [NUM_CH-1:0] cfg_pending
);

  logic [NUM_CH-1:0] wr_en;

  // Channel decode. A channel accepts a write only while it has nothing
  // pending. A select beyond NUM_CH-1 (non-power-of-two NUM_CH) reads as
  // ready, and that write is dropped.
  // NOTE: both outputs get a default before the loop, so no path through
  // this block can leave them unassigned and infer a latch.
  always_comb begin
    cfg_ready = 1'b1;
    wr_en     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = ~cfg_pending[i];
        wr_en[i]  = cfg_valid & ~cfg_pending[i];
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ce_channel #(
      .DIV_W    (DIV_W),
      .DIV_INIT (DIV_INIT[i*DIV_W +: DIV_W])
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .pause   (pause),
      .resync  (resync),
      .wr_en   (wr_en[i]),
      .wr_div  (cfg_div),
      .cen     (cen[i]),
      .pending (cfg_pending[i])
    );
  end

endmodule

// File: tb/tb_ce_scheduler.sv
// tb_ce_scheduler -- self-checking bench for ce_scheduler.
//
// The reference model tracks, for each channel, how many running cycles are
// left until the next enable pulse. It also tracks the active divider and a
// one-deep pending slot. Every clock the model is compared with cen,
// cfg_pending and cfg_ready. Explicit checks cover the reset table, pulse
// spacing, back-pressure, pause, resync and asynchronous reset.
module tb_ce_scheduler;
  import ce_sched_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
  localparam int CH_W   = 2;
  localparam logic [NUM_CH*DIV_W-1:0] DIV_INIT = {8'd6, 8'd14, 8'd5, 8'd14};

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              pause = 1'b0;
  logic              resync = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic [NUM_CH-1:0] cen;
  logic [NUM_CH-1:0] cfg_pending;

  ce_scheduler #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DIV_INIT(DIV_INIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .pause       (pause),
    .resync      (resync),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .cen         (cen),
    .cfg_pending (cfg_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int                m_left [NUM_CH];  // running cycles until the next pulse
  int                m_act  [NUM_CH];
  int                m_pval [NUM_CH];
  bit                m_pflg [NUM_CH];
  logic [NUM_CH-1:0] m_cen;

  function automatic int init_div(input int ch);
    logic [NUM_CH*DIV_W-1:0] v;
    v = DIV_INIT;
    return int'(v[ch*DIV_W +: DIV_W]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_act[c]  = init_div(c);
      m_left[c] = m_act[c] + 1;
      m_pflg[c] = 0;
      m_pval[c] = 0;
    end
    m_cen = '0;
  endtask

  function automatic logic model_ready();
    return !m_pflg[int'(cfg_ch)];
  endfunction

  function automatic logic [NUM_CH-1:0] model_pend();
    logic [NUM_CH-1:0] p;
    for (int c = 0; c < NUM_CH; c++) p[c] = m_pflg[c];
    return p;
  endfunction

  // Advances the model by one clock edge. It uses the inputs as they stood at that edge.
  task automatic model_step();
    bit hs;
    hs = cfg_valid && model_ready();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cen[c] = 1'b0;
      if (resync) begin
        if (m_pflg[c]) begin m_act[c] = m_pval[c]; m_pflg[c] = 0; end
        m_left[c] = m_act[c] + 1;
      end else if (!pause) begin
        m_left[c]--;
        if (m_left[c] == 0) begin
          m_cen[c] = 1'b1;
          if (m_pflg[c]) begin m_act[c] = m_pval[c]; m_pflg[c] = 0; end
          m_left[c] = m_act[c] + 1;
        end
      end
    end
    if (hs) begin
      m_pval[int'(cfg_ch)] = int'(cfg_div);
      m_pflg[int'(cfg_ch)] = 1;
    end
  endtask

  // One clock. Inputs must already be driven. It returns #1 after the edge.
  task automatic tick();
    #1;
    check("cfg_ready", cfg_ready, model_ready());
    @(posedge clk);
    model_step();
    #1;
    check("cen", cen, m_cen);
    check("cfg_pending", cfg_pending, model_pend());
  endtask

  task automatic do_reset();
    pause = 0; resync = 0; cfg_valid = 0;
    reset = 1;
    #1;
    model_reset();
    check("rst_cen", cen, '0);
    check("rst_pending", cfg_pending, '0);
    check("rst_ready", cfg_ready, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    reset = 0;
  endtask

  // Ticks until cen[ch] is seen, within a bounded number of cycles.
  task automatic wait_pulse(input int ch, output int n);
    n = 0;
    do begin tick(); n++; end while (!cen[ch] && n < 200);
    check($sformatf("pulse_seen_ch%0d", ch), cen[ch], 1'b1);
  endtask

  task automatic write_cfg(input int ch, input int div);
    cfg_valid = 1; cfg_ch = CH_W'(ch); cfg_div = DIV_W'(div);
    tick();
    cfg_valid = 0;
  endtask

  // ---------------- reset-release table ----------------
  typedef struct {
    int                edge_n;    // input: edges after reset release
    logic [NUM_CH-1:0] exp_cen;   // expected pulses after that edge
    logic [NUM_CH-1:0] exp_pend;
  } vec_t;
  vec_t tbl [11];

  task automatic run_table(input string tag);
    int e;
    e = 0;
    foreach (tbl[k]) begin
      while (e < tbl[k].edge_n) begin tick(); e++; end
      check($sformatf("%s_cen@%0d", tag, tbl[k].edge_n), cen, tbl[k].exp_cen);
      check($sformatf("%s_pend@%0d", tag, tbl[k].edge_n), cfg_pending, tbl[k].exp_pend);
    end
  endtask

  initial begin
    int n;
    int stall;
    int first [NUM_CH];
    logic [NUM_CH-1:0] seen;

    // Defaults: ch0=14 (15), ch1=5 (6), ch2=14 (15), ch3=6 (7).
    tbl[0]  = '{1,  4'b0000, 4'b0000};
    tbl[1]  = '{5,  4'b0000, 4'b0000};
    tbl[2]  = '{6,  4'b0010, 4'b0000};
    tbl[3]  = '{7,  4'b1000, 4'b0000};
    tbl[4]  = '{12, 4'b0010, 4'b0000};
    tbl[5]  = '{14, 4'b1000, 4'b0000};
    tbl[6]  = '{15, 4'b0101, 4'b0000};
    tbl[7]  = '{18, 4'b0010, 4'b0000};
    tbl[8]  = '{21, 4'b1000, 4'b0000};
    tbl[9]  = '{28, 4'b1000, 4'b0000};
    tbl[10] = '{30, 4'b0111, 4'b0000};

    #2;
    do_reset();
    run_table("init");

    // Reprogram the period-6 channel (ch1) to div 2 mid-period.
    do_reset();
    wait_pulse(1, n);
    check("ch1_first_gap", n, 6);
    tick(); tick();
    write_cfg(1, 2);
    check("ch1_pending_set", cfg_pending[1], 1'b1);
    wait_pulse(1, n);
    check("ch1_old_period_tail", n, 3);
    check("ch1_pending_clr", cfg_pending[1], 1'b0);
    wait_pulse(1, n);
    check("ch1_new_gap_a", n, 3);
    wait_pulse(1, n);
    check("ch1_new_gap_b", n, 3);

    // Back-to-back writes to ch1: div 9, then div 3 must stall.
    cfg_valid = 1; cfg_ch = 2'd1; cfg_div = 8'd9;
    tick();
    cfg_div = 8'd3;
    stall = 0;
    #1;
    while (!cfg_ready && stall < 50) begin tick(); stall++; end
    check("b2b_stalled", stall > 0, 1'b1);
    check("b2b_released", stall < 50, 1'b1);
    tick();
    cfg_valid = 0;
    wait_pulse(1, n);
    wait_pulse(1, n);
    check("b2b_final_gap_a", n, 4);
    wait_pulse(1, n);
    check("b2b_final_gap_b", n, 4);

    // Pause at count 3 of ch0, with a config write accepted while paused.
    do_reset();
    tick(); tick(); tick();
    pause = 1;
    seen = '0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin cfg_valid = 1; cfg_ch = 2'd2; cfg_div = 8'd3; end
      if (i == 6) cfg_valid = 0;
      tick();
      seen |= cen;
    end
    check("pause_no_cen", seen, '0);
    check("pause_write_pending", cfg_pending[2], 1'b1);
    pause = 0;
    wait_pulse(0, n);
    check("pause_resume_gap", n, 12);

    // Resync with ch3 div=1 still pending.
    do_reset();
    tick(); tick();
    write_cfg(3, 1);
    check("rs_pending_set", cfg_pending[3], 1'b1);
    resync = 1;
    tick();
    resync = 0;
    check("rs_pending_clr", cfg_pending, '0);
    for (int c = 0; c < NUM_CH; c++) first[c] = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      for (int c = 0; c < NUM_CH; c++) if (cen[c] && first[c] == 0) first[c] = i;
    end
    check("rs_first_ch0", first[0], 15);
    check("rs_first_ch1", first[1], 6);
    check("rs_first_ch2", first[2], 15);
    check("rs_first_ch3", first[3], 2);

    // Asynchronous reset while a pulse is high and writes are pending.
    write_cfg(0, 3);
    write_cfg(2, 7);
    wait_pulse(1, n);
    do_reset();
    run_table("post_rst");

    // Randomised traffic checked against the model each cycle.
    for (int i = 0; i < 4000; i++) begin
      pause     = ($urandom_range(0, 99) < 10);
      resync    = ($urandom_range(0, 99) < 2);
      cfg_valid = ($urandom_range(0, 99) < 30);
      cfg_ch    = CH_W'($urandom_range(0, NUM_CH - 1));
      cfg_div   = DIV_W'($urandom_range(0, 20));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
